pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/forwarding controller for the 5-stage pipeline. Drives the ID/EX register's
//  flush_ID_EX, rD1_fw_op/rD2_fw_op and rD1_fw/rD2_fw, and the PC/IF_ID stall/flush.
//  Keeps a shadow pipeline (EX/MEM/WB) of dest reg, write-enable and load flag.
//  Detects RAW, load-use and taken-branch hazards and sequences stalls/flushes.
// PARAMETERS
//  WB_LOAD  2'b01  WBsel encoding meaning "write back DRAM read data" (load)
//  CNT_W    16     width of stall_cnt performance counter
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  rR1_ID       in   5   ID source register 1
//  rR2_ID       in   5   ID source register 2
//  re1_ID       in   1   ID instruction reads rR1
//  re2_ID       in   1   ID instruction reads rR2
//  wR_ID        in   5   ID destination register
//  RF_we_ID     in   1   ID instruction writes RF
//  WBsel_ID     in   2   ID write-back select
//  npc_op_EX    in   1   branch/jump taken, resolved in EX
//  wD_EX        in   32  ALU result in EX
//  wD_MEM       in   32  write-back value in MEM (incl. load data)
//  wD_WB        in   32  write-back value in WB
//  stall_PC     out  1   hold PC
//  stall_IF_ID  out  1   hold IF/ID register
//  flush_IF_ID  out  1   zero IF/ID register
//  flush_ID_EX  out  1   insert bubble into ID/EX
//  rD1_fw_op    out  1   replace rD1 with rD1_fw
//  rD2_fw_op    out  1   replace rD2 with rD2_fw
//  rD1_fw       out  32  forwarded operand 1
//  rD2_fw       out  32  forwarded operand 2
//  state        out  2   FSM state: 0 RUN, 1 STALL, 2 FLUSH
//  stall_cnt    out  CNT_W  count of stall cycles, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, shadow stages invalid (we=0), stall_cnt 0.
//  match(S,r): shadow stage S has we=1, wR==r, r!=0, and the matching re is 1.
//  Outputs are combinational from inputs, shadow stages and state; zero latency.
//  Load-use: match(EX,r) with EX.load=1 -> stall_PC=stall_IF_ID=flush_ID_EX=1.
//    This lasts 1 cycle; the load then moves to MEM and is forwarded from wD_MEM.
//  Forward priority EX > MEM > WB per operand: fw_op=1, fw = wD_EX/wD_MEM/wD_WB.
//    No fw_op while stalling.
//  Taken branch (npc_op_EX=1): flush_IF_ID=flush_ID_EX=1, no stall.
//    Branch overrides a load-use stall in the same cycle.
//  Shadow shift every clk: WB<=MEM; MEM<=EX;
//    EX<=(flush_ID_EX ? bubble : {wR_ID,RF_we_ID,WBsel_ID==WB_LOAD}).
//  FSM: RUN->STALL on stall; STALL->RUN when no stall; any->FLUSH on taken branch;
//    FLUSH->RUN next cycle. In FLUSH, ID holds a bubble: no hazard checks, all outs 0.
//  stall_cnt +1 per cycle with stall_PC=1; saturates at all-ones.
//  Reset mid-stall/flush: immediate return to reset values; in-flight shadows dropped.
// CONFIGURATION
//  HAZARD_FORWARD_EN defined: forwarding as above.
//  Undefined: fw_op/fw are always 0. Any match in EX, MEM or WB stalls
//    (stall_PC=stall_IF_ID=flush_ID_EX=1) until the producer leaves WB.
//    Branch handling unchanged.
// TESTING
//  add x5 in EX, ID reads x5 -> rD1_fw_op=1, rD1_fw=wD_EX (0x0000_1234), no stall.
//  lw x6 in EX, ID reads x6 via rR2 -> 1 stall cycle, flush_ID_EX=1;
//    next cycle rD2_fw=wD_MEM, stall_cnt=1.
//  x5 written in both EX and MEM -> EX value forwarded (priority check).
//  Writer targets x0, ID reads x0 -> no fw_op, no stall.
//  npc_op_EX=1 together with load-use -> flush_IF_ID=flush_ID_EX=1, stall_PC=0,
//    state=FLUSH then RUN.
//  Without HAZARD_FORWARD_EN, add x7 then ID reads x7 -> 3 stall cycles, fw_op never 1.
//  rst_n low during STALL -> all outputs 0, stall_cnt 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, operand forwarding and stall/flush
// sequencing for the 5-stage pipeline.
// A shadow copy of the EX/MEM/WB destination info (dest reg, write enable,
// load flag) is kept here so hazards can be resolved without tapping the
// datapath pipeline registers.
// Build option: define HAZARD_FORWARD_EN to enable EX/MEM/WB forwarding.
// Without it, every RAW dependency stalls until the producer leaves WB.
// Hazard outputs are combinational (zero latency). state and stall_cnt are
// registered.

module pipe_hazard_ctrl #(
  parameter logic [1:0]  WB_LOAD = 2'b01,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rR1_ID,
  input  logic [4:0]        rR2_ID,
  input  logic              re1_ID,
  input  logic              re2_ID,
  input  logic [4:0]        wR_ID,
  input  logic              RF_we_ID,
  input  logic [1:0]        WBsel_ID,
  input  logic              npc_op_EX,
  input  logic [31:0]       wD_EX,
  input  logic [31:0]       wD_MEM,
  input  logic [31:0]       wD_WB,
  output logic              stall_PC,
  output logic              stall_IF_ID,
  output logic              flush_IF_ID,
  output logic              flush_ID_EX,
  output logic              rD1_fw_op,
  output logic              rD2_fw_op,
  output logic [31:0]       rD1_fw,
  output logic [31:0]       rD2_fw,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Destination info carried alongside one pipeline stage
  typedef struct packed {
    logic [REG_W-1:0] wr;
    logic             we;
    logic             load;
  } shadow_t;

  shadow_t              r_ex;
  shadow_t              r_mem;
  shadow_t              r_wb;
  state_e               r_state;
  logic [CNT_W-1:0]     r_stall_cnt;

  shadow_t              w_id_entry;
  logic                 w_m1_ex;
  logic                 w_m1_mem;
  logic                 w_m1_wb;
  logic                 w_m2_ex;
  logic                 w_m2_mem;
  logic                 w_m2_wb;
  logic                 w_hazard;
  logic                 w_stall;
  logic                 w_flush_if_id;
  logic                 w_flush_id_ex;
  logic                 w_fw1_op;
  logic                 w_fw2_op;
  logic [DATA_W-1:0]    w_fw1;
  logic [DATA_W-1:0]    w_fw2;
  logic                 w_unused_ok;

  // A stage produces a value the ID instruction actually reads (x0 never does)
  function automatic logic f_match(input shadow_t s, input logic [REG_W-1:0] r,
                                   input logic re);
    return s.we && (s.wr == r) && (r != '0) && re;
  endfunction

  // Source-operand match per stage
  always_comb begin
    w_m1_ex  = f_match(r_ex,  rR1_ID, re1_ID);
    w_m1_mem = f_match(r_mem, rR1_ID, re1_ID);
    w_m1_wb  = f_match(r_wb,  rR1_ID, re1_ID);
    w_m2_ex  = f_match(r_ex,  rR2_ID, re2_ID);
    w_m2_mem = f_match(r_mem, rR2_ID, re2_ID);
    w_m2_wb  = f_match(r_wb,  rR2_ID, re2_ID);
  end

  // Which dependencies cannot be covered and must stall
`ifdef HAZARD_FORWARD_EN
  // Only a load in EX is too late to forward; one bubble moves it to MEM
  assign w_hazard    = (w_m1_ex | w_m2_ex) & r_ex.load;
  assign w_unused_ok = r_wb.load;
`else
  // No bypass network: wait until the producer has retired from WB
  assign w_hazard    = w_m1_ex | w_m1_mem | w_m1_wb | w_m2_ex | w_m2_mem | w_m2_wb;
  assign w_unused_ok = ^{wD_EX, wD_MEM, wD_WB, r_wb.load};
`endif

  // Hazard resolution: branch flush beats stall beats forwarding
  always_comb begin
    w_stall       = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_fw1_op      = 1'b0;
    w_fw2_op      = 1'b0;
    w_fw1         = '0;
    w_fw2         = '0;
    // FLUSH cycle: ID holds the bubble from the branch, nothing to check
    if (rst_n && (r_state != ST_FLUSH)) begin
      if (npc_op_EX) begin
        w_flush_if_id = 1'b1;
        w_flush_id_ex = 1'b1;
      end else if (w_hazard) begin
        w_stall       = 1'b1;
        w_flush_id_ex = 1'b1;
      end
`ifdef HAZARD_FORWARD_EN
      else begin
        // Youngest producer wins for each operand
        if (w_m1_ex) begin
          w_fw1_op = 1'b1;
          w_fw1    = wD_EX;
        end else if (w_m1_mem) begin
          w_fw1_op = 1'b1;
          w_fw1    = wD_MEM;
        end else if (w_m1_wb) begin
          w_fw1_op = 1'b1;
          w_fw1    = wD_WB;
        end
        if (w_m2_ex) begin
          w_fw2_op = 1'b1;
          w_fw2    = wD_EX;
        end else if (w_m2_mem) begin
          w_fw2_op = 1'b1;
          w_fw2    = wD_MEM;
        end else if (w_m2_wb) begin
          w_fw2_op = 1'b1;
          w_fw2    = wD_WB;
        end
      end
`endif
    end
  end

  // Shadow entry for the instruction leaving ID
  always_comb begin
    w_id_entry      = '0;
    w_id_entry.wr   = wR_ID;
    w_id_entry.we   = RF_we_ID;
    w_id_entry.load = (WBsel_ID == WB_LOAD);
  end

  // Shadow pipeline, FSM and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_ex  <= w_flush_id_ex ? shadow_t'('0) : w_id_entry;
      r_mem <= r_ex;
      r_wb  <= r_mem;
      case (r_state)
        // EX holds the flushed bubble during FLUSH, so no branch can resolve
        ST_FLUSH: r_state <= ST_RUN;
        default: begin
          if (npc_op_EX) begin
            r_state <= ST_FLUSH;
          end else if (w_stall) begin
            r_state <= ST_STALL;
          end else begin
            r_state <= ST_RUN;
          end
        end
      endcase
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_PC    = w_stall;
  assign stall_IF_ID = w_stall;
  assign flush_IF_ID = w_flush_if_id;
  assign flush_ID_EX = w_flush_id_ex;
  assign rD1_fw_op   = w_fw1_op;
  assign rD2_fw_op   = w_fw2_op;
  assign rD1_fw      = w_fw1;
  assign rD2_fw      = w_fw2;
  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle vector table with hand-derived
// expectations for the configured build, plus branch and reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] V_EX  = 32'h0000_1234;
  localparam logic [31:0] V_MEM = 32'h0000_5678;
  localparam logic [31:0] V_WB  = 32'h0000_9ABC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        rR1_ID, rR2_ID, wR_ID;
  logic              re1_ID, re2_ID, RF_we_ID, npc_op_EX;
  logic [1:0]        WBsel_ID;
  logic [31:0]       wD_EX, wD_MEM, wD_WB;
  logic              stall_PC, stall_IF_ID, flush_IF_ID, flush_ID_EX;
  logic              rD1_fw_op, rD2_fw_op;
  logic [31:0]       rD1_fw, rD2_fw;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_hazard_ctrl #(.WB_LOAD(2'b01), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rR1_ID(rR1_ID), .rR2_ID(rR2_ID), .re1_ID(re1_ID), .re2_ID(re2_ID),
    .wR_ID(wR_ID), .RF_we_ID(RF_we_ID), .WBsel_ID(WBsel_ID), .npc_op_EX(npc_op_EX),
    .wD_EX(wD_EX), .wD_MEM(wD_MEM), .wD_WB(wD_WB),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
    .flush_ID_EX(flush_ID_EX), .rD1_fw_op(rD1_fw_op), .rD2_fw_op(rD2_fw_op),
    .rD1_fw(rD1_fw), .rD2_fw(rD2_fw), .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rr1;
    logic [4:0] rr2;
    logic       re1;
    logic       re2;
    logic [4:0] wr;
    logic       we;
    logic [1:0] wbsel;
    logic       npc;
  } in_t;

  typedef struct {
    logic        stall;
    logic        flush_if;
    logic        flush_ex;
    logic        fw1_op;
    logic        fw2_op;
    logic [31:0] fw1;
    logic [31:0] fw2;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t mk_in(input logic [4:0] rr1, input logic [4:0] rr2,
                                input logic re1, input logic re2,
                                input logic [4:0] wr, input logic we,
                                input logic [1:0] wbsel, input logic npc);
    in_t r;
    r.rr1 = rr1; r.rr2 = rr2; r.re1 = re1; r.re2 = re2;
    r.wr = wr; r.we = we; r.wbsel = wbsel; r.npc = npc;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic stall, input logic fl_if, input logic fl_ex,
                                  input logic f1op, input logic f2op,
                                  input logic [31:0] f1, input logic [31:0] f2,
                                  input logic [1:0] st, input logic [15:0] cnt);
    exp_t r;
    r.stall = stall; r.flush_if = fl_if; r.flush_ex = fl_ex;
    r.fw1_op = f1op; r.fw2_op = f2op; r.fw1 = f1; r.fw2 = f2;
    r.st = st; r.cnt = cnt;
    return r;
  endfunction

  function automatic in_t nop();
    return mk_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
  endfunction

  function automatic exp_t quiet(input logic [1:0] st, input logic [15:0] cnt);
    return mk_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, st, cnt);
  endfunction

  function automatic exp_t stalled(input logic [1:0] st, input logic [15:0] cnt);
    return mk_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, st, cnt);
  endfunction

  task automatic add(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    rR1_ID = i.rr1; rR2_ID = i.rr2; re1_ID = i.re1; re2_ID = i.re2;
    wR_ID = i.wr; RF_we_ID = i.we; WBsel_ID = i.wbsel; npc_op_EX = i.npc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: no expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " stall_PC"},    32'(stall_PC),    32'(e.stall));
      check({tag, " stall_IF_ID"}, 32'(stall_IF_ID), 32'(e.stall));
      check({tag, " flush_IF_ID"}, 32'(flush_IF_ID), 32'(e.flush_if));
      check({tag, " flush_ID_EX"}, 32'(flush_ID_EX), 32'(e.flush_ex));
      check({tag, " rD1_fw_op"},   32'(rD1_fw_op),   32'(e.fw1_op));
      check({tag, " rD2_fw_op"},   32'(rD2_fw_op),   32'(e.fw2_op));
      check({tag, " rD1_fw"},      rD1_fw,           e.fw1);
      check({tag, " rD2_fw"},      rD2_fw,           e.fw2);
      check({tag, " state"},       32'(state),       32'(e.st));
      check({tag, " stall_cnt"},   32'(stall_cnt),   32'(e.cnt));
    end
  endtask

  // One pipeline cycle: drive after the edge, sample at the falling edge
  task automatic step(input in_t i, input exp_t e, input string tag);
    drive(i);
    sb.push_back(e);
    @(negedge clk);
    check_outs(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    logic [15:0] fc;
    in_t         t;

`ifdef HAZARD_FORWARD_EN
    add(nop(),                                     quiet(2'd0, 16'd0));
    add(mk_in(0, 0, 0, 0, 5, 1, 0, 0),             quiet(2'd0, 16'd0));    // add x5
    add(mk_in(5, 0, 1, 0, 5, 1, 0, 0),
        mk_exp(0, 0, 0, 1, 0, V_EX, 32'd0, 2'd0, 16'd0));                  // EX fwd, x5 again
    add(mk_in(5, 5, 1, 1, 0, 0, 0, 0),
        mk_exp(0, 0, 0, 1, 1, V_EX, V_EX, 2'd0, 16'd0));                   // EX beats MEM
    add(mk_in(5, 5, 0, 1, 0, 0, 0, 0),
        mk_exp(0, 0, 0, 0, 1, 32'd0, V_MEM, 2'd0, 16'd0));                 // MEM fwd, re1 off
    add(mk_in(5, 0, 1, 0, 0, 0, 0, 0),
        mk_exp(0, 0, 0, 1, 0, V_WB, 32'd0, 2'd0, 16'd0));                  // WB fwd
    add(mk_in(0, 0, 0, 0, 0, 1, 0, 0),             quiet(2'd0, 16'd0));    // writes x0
    add(mk_in(0, 0, 1, 1, 0, 0, 0, 0),             quiet(2'd0, 16'd0));    // reads x0
    add(mk_in(0, 0, 0, 0, 6, 1, 1, 0),             quiet(2'd0, 16'd0));    // lw x6
    add(mk_in(6, 6, 0, 1, 9, 1, 0, 0),             stalled(2'd0, 16'd0));  // load-use
    add(mk_in(6, 6, 0, 1, 9, 1, 0, 0),
        mk_exp(0, 0, 0, 0, 1, 32'd0, V_MEM, 2'd1, 16'd1));                 // load data from MEM
    add(nop(),                                     quiet(2'd0, 16'd1));
    add(mk_in(0, 0, 0, 0, 12, 1, 0, 0),            quiet(2'd0, 16'd1));    // add x12
    add(mk_in(12, 12, 0, 0, 0, 0, 0, 0),           quiet(2'd0, 16'd1));    // re gating
    add(nop(),                                     quiet(2'd0, 16'd1));
`else
    add(nop(),                                     quiet(2'd0, 16'd0));
    add(mk_in(0, 0, 0, 0, 7, 1, 0, 0),             quiet(2'd0, 16'd0));    // add x7
    add(mk_in(7, 0, 1, 0, 11, 1, 0, 0),            stalled(2'd0, 16'd0));  // x7 in EX
    add(mk_in(7, 0, 1, 0, 11, 1, 0, 0),            stalled(2'd1, 16'd1));  // x7 in MEM
    add(mk_in(7, 0, 1, 0, 11, 1, 0, 0),            stalled(2'd1, 16'd2));  // x7 in WB
    add(mk_in(7, 0, 1, 0, 11, 1, 0, 0),            quiet(2'd1, 16'd3));    // retired
    add(mk_in(0, 0, 0, 0, 0, 1, 0, 0),             quiet(2'd0, 16'd3));    // writes x0
    add(mk_in(0, 0, 1, 1, 0, 0, 0, 0),             quiet(2'd0, 16'd3));    // reads x0
    add(mk_in(11, 11, 0, 1, 0, 0, 0, 0),           stalled(2'd0, 16'd3));  // x11 in WB
    add(mk_in(11, 11, 0, 1, 0, 0, 0, 0),           quiet(2'd1, 16'd4));
    add(mk_in(0, 0, 0, 0, 12, 1, 0, 0),            quiet(2'd0, 16'd4));    // add x12
    add(mk_in(12, 12, 0, 0, 0, 0, 0, 0),           quiet(2'd0, 16'd4));    // re gating
    add(nop(),                                     quiet(2'd0, 16'd4));
    add(nop(),                                     quiet(2'd0, 16'd4));
`endif

    wD_EX  = V_EX;
    wD_MEM = V_MEM;
    wD_WB  = V_WB;
    drive(nop());
    rst_n = 1'b0;
    #12;
    sb.push_back(quiet(2'd0, 16'd0));
    check_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) step(vecs[k].i, vecs[k].e, $sformatf("vec%0d", k));
    fc = vecs[vecs.size() - 1].e.cnt;

    // Taken branch together with a load-use hazard
    step(mk_in(0, 0, 0, 0, 10, 1, 1, 0), quiet(2'd0, fc), "br_lw");
    drive(mk_in(10, 0, 1, 0, 3, 1, 0, 1));
    @(negedge clk);
    check("br stall_PC",    32'(stall_PC),    32'd0);
    check("br stall_IF_ID", 32'(stall_IF_ID), 32'd0);
    check("br flush_IF_ID", 32'(flush_IF_ID), 32'd1);
    check("br flush_ID_EX", 32'(flush_ID_EX), 32'd1);
    check("br state",       32'(state),       32'd0);
    @(posedge clk);
    #1;
    // FLUSH cycle ignores a pending dependency on the load
    step(mk_in(10, 0, 1, 0, 0, 0, 0, 0), quiet(2'd2, fc), "br_flush");
    step(nop(), quiet(2'd0, fc), "br_run");

    // Reset while stalled drops state, counter and in-flight shadows
    step(mk_in(0, 0, 0, 0, 7, 1, 1, 0), quiet(2'd0, fc), "rs_lw");
    t = mk_in(7, 0, 1, 0, 0, 0, 0, 0);
    step(t, stalled(2'd0, fc), "rs_use");
    drive(t);
    @(negedge clk);
    check("rs pre state", 32'(state),     32'd1);
    check("rs pre cnt",   32'(stall_cnt), 32'(fc + 16'd1));
    #2;
    rst_n = 1'b0;
    npc_op_EX = 1'b1;
    #1;
    sb.push_back(quiet(2'd0, 16'd0));
    check_outs("rs_low");
    npc_op_EX = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sb.push_back(quiet(2'd0, 16'd0));
    check_outs("rs_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
